// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: datapath control word, decoder schedule and sequencer states.
// Every decoder, sequencer and datapath file imports these so the encodings stay in one place.
package gb_cpu_common_pkg;

    localparam int MAX_MCYCLES = 6;
    localparam int MC_W        = $clog2(MAX_MCYCLES);

    localparam logic [MC_W-1:0] COND_NONE = 3'd7;
    localparam logic [MC_W-1:0] MAX_LEN   = 3'(MAX_MCYCLES);

    typedef struct packed {
        logic [1:0] addr_sel;   // 0 = PC, 1 = HL, 2 = SP, 3 = temp address
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_load;
        logic       pc_inc;
        logic [3:0] alu_op;
        logic [2:0] reg_src;
        logic [2:0] reg_dst;
    } control_word_t;

    localparam control_word_t NOP_CTRL   = '0;
    localparam control_word_t FETCH_CTRL = '{
        addr_sel: 2'd0, mem_rd: 1'b1, mem_wr: 1'b0, ir_load: 1'b1, pc_inc: 1'b1,
        alu_op: 4'd0, reg_src: 3'd0, reg_dst: 3'd0
    };

    typedef struct packed {
        logic [MC_W-1:0]                    len;
        control_word_t [MAX_MCYCLES-1:0]    cycles;
        logic [MC_W-1:0]                    cond_cycle;
        logic                               cb_next;
        logic                               halt;
    } schedule_t;

    // S_SHORT is the fetch cycle that replaces the tail of a not-taken conditional.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHORT = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: walks the decoder schedule one control word per clock, with
// conditional shortcut, CB-prefix hand-back, memory stall and HALT.
module gb_cpu_sequencer
    import gb_cpu_common_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  schedule_t       schedule,
    input  logic            cond_met,
    input  logic            stall,
    input  logic            wake,
    output logic            cb_prefix,
    output control_word_t   ctrl,
    output logic [2:0]      mcycle,
    output logic            instr_done,
    output logic            halted,
    output logic [1:0]      dbg_state
);

    seq_state_t         state_q;
    logic [MC_W-1:0]    m_q;
    schedule_t          sched_q;
    logic               cb_q;

    schedule_t          cur;
    logic [MC_W-1:0]    eff_len;
    logic [MC_W-1:0]    last_m;
    logic               is_last;
    logic               cond_skip;

    // Cycle 0 reads the live decoder output; later cycles replay the latched copy
    // so IR may be reloaded by the overlapped fetch without disturbing us.
    always_comb begin
        cur       = (state_q == S_EXEC && m_q == '0) ? schedule : sched_q;
        eff_len   = (cur.len == '0 || cur.len > MAX_LEN) ? 3'd1 : cur.len;
        last_m    = eff_len - 3'd1;
        is_last   = (state_q == S_EXEC) && (m_q == last_m);
        cond_skip = (state_q == S_EXEC) && (cur.cond_cycle != COND_NONE) &&
                    (cur.cond_cycle < last_m) && (m_q == cur.cond_cycle) && !cond_met;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            m_q     <= '0;
            cb_q    <= 1'b0;
            sched_q <= '0;
        end else if (!stall) begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_EXEC;
                    m_q     <= '0;
                    cb_q    <= 1'b0;
                end
                S_EXEC: begin
                    if (m_q == '0)
                        sched_q <= schedule;
                    if (is_last) begin
                        cb_q    <= cur.cb_next;
                        m_q     <= '0;
                        state_q <= cur.halt ? S_HALT : S_EXEC;
                    end else begin
                        m_q <= m_q + 3'd1;
                        if (cond_skip)
                            state_q <= S_SHORT;
                    end
                end
                S_SHORT: begin
                    cb_q    <= sched_q.cb_next;
                    m_q     <= '0;
                    state_q <= S_EXEC;
                end
                S_HALT: begin
                    if (wake)
                        state_q <= S_BOOT;
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        ctrl       = NOP_CTRL;
        instr_done = 1'b0;
        halted     = 1'b0;
        mcycle     = '0;
        if (rst_n) begin
            case (state_q)
                S_BOOT: begin
                    ctrl       = FETCH_CTRL;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    ctrl       = cur.cycles[m_q];
                    instr_done = is_last;
                    mcycle     = m_q;
                end
                S_SHORT: begin
                    ctrl       = FETCH_CTRL;
                    instr_done = 1'b1;
                    mcycle     = m_q;
                end
                S_HALT: halted = 1'b1;
                default: ctrl = NOP_CTRL;
            endcase
        end
    end

    assign cb_prefix = cb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed bench for gb_cpu_sequencer: each task drives one scenario and checks
// ctrl/instr_done/mcycle (packed as one word) plus cb_prefix and halted per clock.
module tb_gb_cpu_sequencer;
    import gb_cpu_common_pkg::*;

    logic           clk;
    logic           rst_n;
    schedule_t      schedule;
    logic           cond_met;
    logic           stall;
    logic           wake;
    logic           cb_prefix;
    control_word_t  ctrl;
    logic [2:0]     mcycle;
    logic           instr_done;
    logic           halted;
    logic [1:0]     dbg_state;

    int n_pass;
    int n_total;

    localparam logic [15:0] FETCH_W = 16'h2C00;
    localparam logic [15:0] NOP_W   = 16'h0000;

    gb_cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .schedule(schedule), .cond_met(cond_met),
        .stall(stall), .wake(wake), .cb_prefix(cb_prefix), .ctrl(ctrl),
        .mcycle(mcycle), .instr_done(instr_done), .halted(halted), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cw(input logic [7:0] k);
        return {8'h40, k};
    endfunction

    function automatic schedule_t mk_sched(input logic [2:0] len, input logic [7:0] base,
                                           input logic [2:0] cc, input logic cb, input logic h);
        schedule_t s;
        s = '0;
        s.len = len;
        for (int i = 0; i < MAX_MCYCLES; i++) s.cycles[i] = cw(base + 8'(i));
        s.cond_cycle = cc;
        s.cb_next = cb;
        s.halt = h;
        return s;
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow one unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] exp_w;
        rst_n = 1'b0; stall = 1'b0; wake = 1'b0; cond_met = 1'b0;
        schedule = mk_sched(3'd1, 8'h10, 3'd7, 1'b0, 1'b0);
        tick(); tick();
        #1;
        exp_w = {NOP_W, 1'b0, 3'd0};
        n_total++;
        if ({ctrl, instr_done, mcycle} !== exp_w)
            $display("FAIL reset_out got=%h exp=%h", {ctrl, instr_done, mcycle}, exp_w);
        else n_pass++;
        n_total++;
        if ({halted, cb_prefix, dbg_state} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {halted, cb_prefix, dbg_state});
        else n_pass++;
        rst_n = 1'b1;
        #1;
        exp_w = {FETCH_W, 1'b1, 3'd0};
        n_total++;
        if ({ctrl, instr_done, mcycle} !== exp_w)
            $display("FAIL boot_fetch got=%h exp=%h", {ctrl, instr_done, mcycle}, exp_w);
        else n_pass++;
        tick();
        #1;
        exp_w = {cw(8'h10), 1'b1, 3'd0};
        n_total++;
        if ({ctrl, instr_done, mcycle, cb_prefix} !== {exp_w, 1'b0})
            $display("FAIL add_len1 got=%h exp=%h", {ctrl, instr_done, mcycle, cb_prefix}, {exp_w, 1'b0});
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        logic [19:0] exp_w;
        int clocks;
        int rises;
        logic prev_done;
        logic finished;
        clocks = 0; rises = 0; prev_done = 1'b0; finished = 1'b0;
        schedule = mk_sched(3'd2, 8'h20, 3'd7, 1'b0, 1'b0);
        for (int c = 0; c < 10 && !finished; c++) begin
            stall = (c >= 1 && c <= 3);
            if (c == 1) schedule = mk_sched(3'd1, 8'h30, 3'd7, 1'b0, 1'b0);
            #1;
            clocks++;
            if (instr_done && !prev_done) rises++;
            prev_done = instr_done;
            exp_w = (c == 0) ? {cw(8'h20), 1'b0, 3'd0} : {cw(8'h21), instr_done, 3'd1};
            n_total++;
            if ({ctrl, instr_done, mcycle} !== exp_w)
                $display("FAIL stall_cycle c=%0d got=%h exp=%h", c, {ctrl, instr_done, mcycle}, exp_w);
            else n_pass++;
            if (instr_done && !stall) finished = 1'b1;
            tick();
        end
        stall = 1'b0;
        n_total++;
        if ({clocks, rises} !== {32'd5, 32'd1})
            $display("FAIL stall_len clocks=%0d rises=%0d exp clocks=5 rises=1", clocks, rises);
        else n_pass++;
    endtask

    task automatic test_cond();
        logic [19:0] got;
        logic [19:0] exp_nt [2];
        logic [19:0] exp_t  [3];
        exp_nt[0] = {cw(8'h40), 1'b0, 3'd0};
        exp_nt[1] = {FETCH_W,   1'b1, 3'd1};
        exp_t[0]  = {cw(8'h40), 1'b0, 3'd0};
        exp_t[1]  = {cw(8'h41), 1'b0, 3'd1};
        exp_t[2]  = {cw(8'h42), 1'b1, 3'd2};
        cond_met = 1'b0;
        schedule = mk_sched(3'd3, 8'h40, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1; got = {ctrl, instr_done, mcycle};
            n_total++;
            if (got !== exp_nt[c]) $display("FAIL cond_not_taken c=%0d got=%h exp=%h", c, got, exp_nt[c]);
            else n_pass++;
            tick();
        end
        cond_met = 1'b1;
        schedule = mk_sched(3'd3, 8'h40, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1; got = {ctrl, instr_done, mcycle};
            n_total++;
            if (got !== exp_t[c]) $display("FAIL cond_taken c=%0d got=%h exp=%h", c, got, exp_t[c]);
            else n_pass++;
            tick();
            schedule = mk_sched(3'd1, 8'h70, 3'd7, 1'b0, 1'b0);
        end
        // cond_cycle on the last cycle has no effect
        cond_met = 1'b0;
        schedule = mk_sched(3'd2, 8'h50, 3'd1, 1'b0, 1'b0);
        tick();
        #1; got = {ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {cw(8'h51), 1'b1, 3'd1}) $display("FAIL cond_last got=%h exp=%h", got, {cw(8'h51), 1'b1, 3'd1});
        else n_pass++;
        tick();
        schedule = mk_sched(3'd0, 8'h60, 3'd7, 1'b0, 1'b0);
        #1; got = {ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {cw(8'h60), 1'b1, 3'd0}) $display("FAIL len0 got=%h exp=%h", got, {cw(8'h60), 1'b1, 3'd0});
        else n_pass++;
        tick();
        schedule = mk_sched(3'd7, 8'h68, 3'd7, 1'b0, 1'b0);
        #1; got = {ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {cw(8'h68), 1'b1, 3'd0}) $display("FAIL len7 got=%h exp=%h", got, {cw(8'h68), 1'b1, 3'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_cb();
        logic [1:0] exp_cb [4];
        exp_cb[0] = 2'b01; exp_cb[1] = 2'b10; exp_cb[2] = 2'b11; exp_cb[3] = 2'b01;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: schedule = mk_sched(3'd1, 8'h80, 3'd7, 1'b1, 1'b0);
                1: schedule = mk_sched(3'd2, 8'h90, 3'd7, 1'b0, 1'b0);
                2: schedule = mk_sched(3'd1, 8'h98, 3'd7, 1'b0, 1'b0);
                default: schedule = mk_sched(3'd1, 8'h99, 3'd7, 1'b0, 1'b0);
            endcase
            #1;
            n_total++;
            if ({cb_prefix, instr_done} !== exp_cb[c])
                $display("FAIL cb_prefix c=%0d got=%b exp=%b", c, {cb_prefix, instr_done}, exp_cb[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_halt();
        logic [20:0] got;
        schedule = mk_sched(3'd1, 8'hA0, 3'd7, 1'b0, 1'b1);
        wake = 1'b0;
        #1; got = {halted, ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {1'b0, cw(8'hA0), 1'b1, 3'd0}) $display("FAIL halt_instr got=%h", got);
        else n_pass++;
        tick();
        for (int c = 0; c < 12; c++) begin
            wake  = (c >= 10);
            stall = (c == 10);
            #1; got = {halted, ctrl, instr_done, mcycle};
            n_total++;
            if (got !== {1'b1, NOP_W, 1'b0, 3'd0})
                $display("FAIL halted c=%0d got=%h exp=%h", c, got, {1'b1, NOP_W, 1'b0, 3'd0});
            else n_pass++;
            tick();
        end
        wake = 1'b0; stall = 1'b0;
        schedule = mk_sched(3'd1, 8'hA8, 3'd7, 1'b0, 1'b0);
        #1; got = {halted, ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {1'b0, FETCH_W, 1'b1, 3'd0}) $display("FAIL wake_boot got=%h exp=%h", got, {1'b0, FETCH_W, 1'b1, 3'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [20:0] got;
        schedule = mk_sched(3'd1, 8'hB8, 3'd7, 1'b1, 1'b0);
        tick();
        schedule = mk_sched(3'd6, 8'hB0, 3'd7, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1; got = {cb_prefix, ctrl, instr_done, mcycle};
            n_total++;
            if (got !== {1'b1, cw(8'hB0 + 8'(c)), 1'b0, 3'(c)})
                $display("FAIL len6_step c=%0d got=%h exp=%h", c, got, {1'b1, cw(8'hB0 + 8'(c)), 1'b0, 3'(c)});
            else n_pass++;
            if (c < 4) tick();
        end
        rst_n = 1'b0;
        #1; got = {halted, ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {1'b0, NOP_W, 1'b0, 3'd0}) $display("FAIL rst_low got=%h exp=%h", got, {1'b0, NOP_W, 1'b0, 3'd0});
        else n_pass++;
        tick();
        #1; got = {cb_prefix, ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {1'b0, NOP_W, 1'b0, 3'd0}) $display("FAIL rst_held got=%h exp=%h", got, {1'b0, NOP_W, 1'b0, 3'd0});
        else n_pass++;
        rst_n = 1'b1;
        #1; got = {cb_prefix, ctrl, instr_done, mcycle};
        n_total++;
        if (got !== {1'b0, FETCH_W, 1'b1, 3'd0}) $display("FAIL rst_boot got=%h exp=%h", got, {1'b0, FETCH_W, 1'b1, 3'd0});
        else n_pass++;
        tick();
        #1;
        n_total++;
        if ({ctrl, mcycle} !== {cw(8'hB0), 3'd0}) $display("FAIL rst_restart got=%h exp=%h", {ctrl, mcycle}, {cw(8'hB0), 3'd0});
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_stall();
        test_cond();
        test_cb();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
